mux_reduce_pipe: RTL and testbench

MUX_REDUCE_PIPE -- requirements
Module: mux_reduce_pipe

---
 rtl/mux_reduce_pkg.sv | 18 +
 rtl/mux_reduce_pipe_mux2.sv | 11 +
 rtl/mux_reduce_pipe.sv | 122 ++++++++++++
 tb/tb_mux_reduce_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_reduce_pkg.sv
// Shared types and limits for the mux-only reduction pipeline.
package mux_reduce_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } op_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_reduce_pipe_mux2.sv
// Two-input multiplexer: the single logic primitive the reduction tree is built from.
module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_reduce_pipe.sv
// Pipelined AND/OR/XOR/XNOR bit reduction built purely from mux2 cells, one register per tree level.
// Optional 16-bit output-transfer counter port out_count when MUX_REDUCE_TXN_COUNT_EN is defined.
module mux_reduce_pipe
    import mux_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [1:0]       out_op
`ifdef MUX_REDUCE_TXN_COUNT_EN
    ,
    output logic [15:0]      out_count
`endif
);

    localparam int LEVELS = $clog2(WIDTH);
    // All level outputs packed back to back: WIDTH/2 + WIDTH/4 + ... + 1 bits.
    localparam int NBITS  = WIDTH - 1;

    if (!is_pow2(WIDTH) || WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("mux_reduce_pipe: WIDTH must be a power of two in 2..64");
    end

    logic [NBITS-1:0]  data_q, data_d;
    logic [LEVELS-1:0] valid_q, valid_d;
    op_t               op_q [LEVELS];
    op_t               op_d [LEVELS];
    logic              stall;

    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
        localparam int IN_W    = WIDTH >> gi;
        localparam int OUT_W   = IN_W / 2;
        localparam int OUT_OFF = WIDTH - IN_W;
        localparam int IN_OFF  = WIDTH - 2 * IN_W;

        logic [IN_W-1:0] vin;
        op_t             op_in;
        logic [1:0]      opb;

        if (gi == 0) begin : g_first
            assign vin        = in_data;
            assign op_in      = op_t'(in_op);
            assign valid_d[0] = in_valid;
        end else begin : g_next
            assign vin         = data_q[IN_OFF +: IN_W];
            assign op_in       = op_q[gi-1];
            assign valid_d[gi] = valid_q[gi-1];
        end

        assign opb       = op_in;
        assign op_d[gi]  = op_in;

        for (genvar gj = 0; gj < OUT_W; gj++) begin : g_pair
            logic a, b, and_y, or_y, nb, xor_y, ao_y, x_y, y;

            assign a = vin[2*gj];
            assign b = vin[2*gj+1];

            mux2 u_and (.d0(1'b0), .d1(b),    .sel(a), .y(and_y));
            mux2 u_or  (.d0(b),    .d1(1'b1), .sel(a), .y(or_y));
            mux2 u_nb  (.d0(1'b1), .d1(1'b0), .sel(b), .y(nb));
            mux2 u_xor (.d0(b),    .d1(nb),   .sel(a), .y(xor_y));
            mux2 u_ao  (.d0(and_y), .d1(or_y), .sel(opb[0]), .y(ao_y));

            // XNOR rides the XOR path through the tree and is inverted only at the root.
            if (gi == LEVELS - 1) begin : g_root
                logic nx;
                mux2 u_nx (.d0(1'b1),  .d1(1'b0), .sel(xor_y),  .y(nx));
                mux2 u_xn (.d0(xor_y), .d1(nx),   .sel(opb[0]), .y(x_y));
            end else begin : g_inner
                assign x_y = xor_y;
            end

            mux2 u_op (.d0(ao_y), .d1(x_y), .sel(opb[1]), .y(y));

            assign data_d[OUT_OFF+gj] = y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < LEVELS; i++) op_q[i] <= OP_AND;
        end else if (!stall) begin
            data_q  <= data_d;
            valid_q <= valid_d;
            for (int i = 0; i < LEVELS; i++) op_q[i] <= op_d[i];
        end
    end

    assign stall     = valid_q[LEVELS-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = valid_q[LEVELS-1];
    assign out_data  = data_q[NBITS-1];
    assign out_op    = op_q[LEVELS-1];

`ifdef MUX_REDUCE_TXN_COUNT_EN
    logic [15:0] count_q, count_d;

    assign count_d = count_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_valid && out_ready) begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_mux_reduce_pipe.sv
// Directed and randomized checks of mux_reduce_pipe at WIDTH = 2, 8 and 64 (index 0, 1, 2).
module tb_mux_reduce_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       iv  = '0;
    logic [2:0]       orr = '1;
    logic [2:0][63:0] id  = '0;
    logic [2:0][1:0]  io  = '0;
    wire  [2:0]       ir, ov, od;
    wire  [2:0][1:0]  oo;

    int checks = 0;
    int errors = 0;

    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] q2[$];
    int         n_out[3];
    int         widths[3] = '{2, 8, 64};

`ifdef MUX_REDUCE_TXN_COUNT_EN
    wire [15:0] cnt2, cnt8, cnt64;
    logic [15:0] cnt8_model;
    always @(posedge clk or posedge rst) begin
        if (rst) cnt8_model <= '0;
        else if (ov[1] && orr[1]) cnt8_model <= cnt8_model + 16'd1;
    end
`endif

    mux_reduce_pipe #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0][1:0]),
        .in_op(io[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .out_op(oo[0])
`ifdef MUX_REDUCE_TXN_COUNT_EN
        , .out_count(cnt2)
`endif
    );

    mux_reduce_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1][7:0]),
        .in_op(io[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .out_op(oo[1])
`ifdef MUX_REDUCE_TXN_COUNT_EN
        , .out_count(cnt8)
`endif
    );

    mux_reduce_pipe #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .in_op(io[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .out_op(oo[2])
`ifdef MUX_REDUCE_TXN_COUNT_EN
        , .out_count(cnt64)
`endif
    );

    function automatic logic ref_reduce(input logic [63:0] d, input int w, input logic [1:0] op);
        logic r;
        r = d[0];
        for (int i = 1; i < w; i++) begin
            case (op)
                2'd0:    r = r & d[i];
                2'd1:    r = r | d[i];
                default: r = r ^ d[i];
            endcase
        end
        if (op == 2'd3) r = ~r;
        return r;
    endfunction

    task automatic test_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++; if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov[k]); end
            checks++; if (ir[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, ir[k]); end
        end
        checks++; if (od[1] !== 1'b0) begin errors++; $display("FAIL reset_out_data: got %b want 0", od[1]); end
        checks++; if (oo[1] !== 2'd0) begin errors++; $display("FAIL reset_out_op: got %0d want 0", oo[1]); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        logic exp_v, exp_d;
        orr[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            exp_v = (i == 3) || (i == 4);
            exp_d = (i == 3);
            checks++; if (ov[1] !== exp_v) begin errors++; $display("FAIL latency_valid cyc%0d: got %b want %b", i, ov[1], exp_v); end
            if (exp_v) begin
                $display("latency cyc%0d out data=%b op=%0d", i, od[1], oo[1]);
                checks++; if (od[1] !== exp_d) begin errors++; $display("FAIL latency_data cyc%0d: got %b want %b", i, od[1], exp_d); end
            end
            iv[1] = (i < 2);
            id[1] = (i == 0) ? 64'hFF : 64'hFE;
            io[1] = 2'd0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bd[3] = '{8'h00, 8'h07, 8'h07};
        logic [1:0] bo[3] = '{2'd1, 2'd2, 2'd3};
        logic       be[3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            if (i >= 3 && i <= 5) begin
                $display("b2b cyc%0d out data=%b op=%0d", i, od[1], oo[1]);
                checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL b2b_valid cyc%0d: got %b want 1", i, ov[1]); end
                checks++; if (od[1] !== be[i-3]) begin errors++; $display("FAIL b2b_data cyc%0d: got %b want %b", i, od[1], be[i-3]); end
                checks++; if (oo[1] !== bo[i-3]) begin errors++; $display("FAIL b2b_op cyc%0d: got %0d want %0d", i, oo[1], bo[i-3]); end
            end else begin
                checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL b2b_idle cyc%0d: got %b want 0", i, ov[1]); end
            end
            iv[1] = (i < 3);
            if (i < 3) begin id[1] = {56'd0, bd[i]}; io[1] = bo[i]; end
        end
    endtask

    task automatic test_stall();
        logic [7:0] sd[3] = '{8'hFF, 8'h00, 8'h01};
        logic [1:0] so[3] = '{2'd0, 2'd1, 2'd2};
        logic       se[3] = '{1'b1, 1'b0, 1'b1};
        int j;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            orr[1] = !(i >= 3 && i <= 7);
            iv[1]  = (i < 3);
            if (i < 3) begin id[1] = {56'd0, sd[i]}; io[1] = so[i]; end
            #1;
            if (i >= 3 && i <= 10) begin
                j = (i <= 8) ? 0 : i - 8;
                $display("stall cyc%0d out data=%b op=%0d ready=%b", i, od[1], oo[1], orr[1]);
                checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL stall_valid cyc%0d: got %b want 1", i, ov[1]); end
                checks++; if (od[1] !== se[j]) begin errors++; $display("FAIL stall_data cyc%0d: got %b want %b", i, od[1], se[j]); end
                checks++; if (oo[1] !== so[j]) begin errors++; $display("FAIL stall_op cyc%0d: got %0d want %0d", i, oo[1], so[j]); end
                checks++; if (ir[1] !== (i >= 8)) begin errors++; $display("FAIL stall_in_ready cyc%0d: got %b want %b", i, ir[1], (i >= 8)); end
            end else begin
                checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL stall_idle cyc%0d: got %b want 0", i, ov[1]); end
                checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL stall_idle_ready cyc%0d: got %b want 1", i, ir[1]); end
            end
        end
        orr[1] = 1'b1;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv[1] = (i < 2);
            id[1] = 64'hFF;
            io[1] = 2'(i);
        end
        @(negedge clk); #1;
        checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b want 1", ov[1]); end
        #1; rst = 1'b1; #1;
        checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", ov[1]); end
        checks++; if (od[1] !== 1'b0) begin errors++; $display("FAIL arst_data: got %b want 0", od[1]); end
        checks++; if (oo[1] !== 2'd0) begin errors++; $display("FAIL arst_op: got %0d want 0", oo[1]); end
        checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b want 1", ir[1]); end
        @(negedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); #1;
            checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL arst_post_ready cyc%0d: got %b want 1", i, ir[1]); end
            if (i == 6) begin
                $display("arst cyc%0d out data=%b op=%0d", i, od[1], oo[1]);
                checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL arst_new_valid: got %b want 1", ov[1]); end
                checks++; if (od[1] !== 1'b1) begin errors++; $display("FAIL arst_new_data: got %b want 1", od[1]); end
                checks++; if (oo[1] !== 2'd3) begin errors++; $display("FAIL arst_new_op: got %0d want 3", oo[1]); end
            end else begin
                checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL arst_stale cyc%0d: got %b want 0", i, ov[1]); end
            end
            iv[1] = (i == 3);
            id[1] = 64'h00;
            io[1] = 2'd3;
        end
    endtask

    task automatic rand_cycle(input bit drain);
        logic [2:0] got;
        logic       have;
        logic       exp_ir;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            iv[k]  = drain ? 1'b0 : 1'($urandom_range(0, 1));
            orr[k] = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            id[k]  = {$urandom, $urandom};
            io[k]  = 2'($urandom_range(0, 3));
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_ir = !(ov[k] && !orr[k]);
            checks++; if (ir[k] !== exp_ir) begin errors++; $display("FAIL rand_in_ready w%0d: got %b want %b", widths[k], ir[k], exp_ir); end
            if (iv[k] && ir[k]) begin
                got = {io[k], ref_reduce(id[k], widths[k], io[k])};
                case (k)
                    0:       q0.push_back(got);
                    1:       q1.push_back(got);
                    default: q2.push_back(got);
                endcase
            end
            if (ov[k] && orr[k]) begin
                have = 1'b0;
                got  = '0;
                case (k)
                    0:       if (q0.size() > 0) begin got = q0.pop_front(); have = 1'b1; end
                    1:       if (q1.size() > 0) begin got = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin got = q2.pop_front(); have = 1'b1; end
                endcase
                n_out[k]++;
                $display("rand w%0d #%0d out data=%b op=%0d", widths[k], n_out[k], od[k], oo[k]);
                checks++;
                if (!have) begin
                    errors++; $display("FAIL rand_spurious w%0d: got data=%b op=%0d want none", widths[k], od[k], oo[k]);
                end else if ({oo[k], od[k]} !== got) begin
                    errors++; $display("FAIL rand_result w%0d: got op=%0d data=%b want op=%0d data=%b", widths[k], oo[k], od[k], got[2:1], got[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        for (int k = 0; k < 3; k++) n_out[k] = 0;
        while ((n_out[0] < 1000 || n_out[1] < 1000 || n_out[2] < 1000) && cyc < 20000) begin
            rand_cycle(1'b0);
            cyc++;
        end
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout: got %0d/%0d/%0d transfers want 1000 each", n_out[0], n_out[1], n_out[2]); end
        for (int i = 0; i < 10; i++) rand_cycle(1'b1);
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL rand_lost w2: got %0d pending want 0", q0.size()); end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL rand_lost w8: got %0d pending want 0", q1.size()); end
        checks++; if (q2.size() != 0) begin errors++; $display("FAIL rand_lost w64: got %0d pending want 0", q2.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_random();
`ifdef MUX_REDUCE_TXN_COUNT_EN
        #1;
        checks++; if (cnt8 !== cnt8_model) begin errors++; $display("FAIL out_count: got %0d want %0d", cnt8, cnt8_model); end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
